// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for a single-cycle RISC-V core.
// One-word lines; misses and every store go to main memory over a level req / pulse ack handshake.
module data_cache_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned INDEX_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
    localparam int unsigned LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [DATA_W-1:0]   data_arr [LINES];
    logic                req_hit;

    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic                unused_adr_bits;

    assign index           = DataAdr[INDEX_W+1:2];
    assign tag             = DataAdr[ADDR_W-1:INDEX_W+2];
    assign req_index       = mem_addr[INDEX_W+1:2];
    assign req_tag         = mem_addr[ADDR_W-1:INDEX_W+2];
    assign unused_adr_bits = ^DataAdr[1:0];

    assign hit = valid[index] && (tag_arr[index] == tag);

    // Invalid lines read as zero so the datapath never sees uninitialised array contents.
    assign ReadData = valid[index] ? data_arr[index] : '0;

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = MemWrite | (MemRead & ~hit);
            RD_MISS: stall = 1'b1;
            WR_THRU: stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Control FSM, memory request registers and line valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_hit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemWrite) begin
                        state     <= WR_THRU;
                        mem_wr    <= 1'b1;
                        mem_addr  <= {DataAdr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= WriteData;
                        req_hit   <= hit;
                    end else if (MemRead && !hit) begin
                        state    <= RD_MISS;
                        mem_rd   <= 1'b1;
                        mem_addr <= {DataAdr[ADDR_W-1:2], 2'b00};
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        state            <= DONE;
                        mem_rd           <= 1'b0;
                        valid[req_index] <= 1'b1;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        state  <= DONE;
                        mem_wr <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays: refill on read-miss completion, update only lines that hit when the store was issued.
    always_ff @(posedge clk) begin
        if (state == RD_MISS && mem_ack) begin
            tag_arr[req_index]  <= req_tag;
            data_arr[req_index] <= mem_rdata;
        end else if (state == WR_THRU && mem_ack && req_hit) begin
            data_arr[req_index] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: directed vector table, reset/stray-ack sequences, then
// random accesses checked against an array-based cache and memory model.
module tb_data_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [9:0]  DataAdr;
    logic [31:0] WriteData, ReadData;
    logic        stall, mem_rd, mem_wr;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [logic [9:0]];
    bit          m_valid [32];
    logic [2:0]  m_tag   [32];
    logic [31:0] m_data  [32];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          delay;
        int          exp_stall;
        bit          chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    data_cache_ctrl dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData), .stall(stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one instruction until it retires, acting as main memory with the given ack delay.
    task automatic run_op(input bit rd, input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                          input int delay, output int stalls, output logic [31:0] rdata);
        logic [9:0] waddr;
        int  req_cycles;
        bit  done;
        waddr      = {addr[9:2], 2'b00};
        req_cycles = 0;
        done       = 1'b0;
        stalls     = 0;
        rdata      = '0;
        if (!mem_model.exists(waddr)) mem_model[waddr] = $urandom;
        MemRead = rd; MemWrite = wr; DataAdr = addr; WriteData = wd;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (mem_rd && mem_wr) check("both_req", 32'(mem_rd & mem_wr), 32'd0);
            if (!stall) begin
                check("no_req_when_free", 32'(mem_rd | mem_wr), 32'd0);
                rdata = ReadData;
                done  = 1'b1;
            end else begin
                stalls++;
                if (stalls == 1) begin
                    check("req_registered", 32'(mem_rd | mem_wr), 32'd0);
                end else if (mem_rd || mem_wr) begin
                    req_cycles++;
                    if (req_cycles == 1) begin
                        check("req_is_wr", 32'(mem_wr), 32'(wr));
                        check("req_is_rd", 32'(mem_rd), 32'(!wr));
                        check("mem_addr", 32'(mem_addr), 32'(waddr));
                        if (wr) check("mem_wdata", mem_wdata, wd);
                    end
                    if (req_cycles == delay) begin
                        mem_ack = 1'b1;
                        if (wr) mem_model[waddr] = wd;
                        else    mem_rdata = mem_model[waddr];
                    end
                end
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        check("retire_timeout", 32'(done), 32'd1);
    endtask

    // Reference cache: predicts stall count and load data, then updates itself.
    task automatic model_step(input bit rd, input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                              input int delay, output int exp_stall, output bit chk_rd,
                              output logic [31:0] exp_rdata);
        int         idx;
        logic [2:0] t;
        logic [9:0] waddr;
        bit         line_hit;
        idx       = int'(addr[6:2]);
        t         = addr[9:7];
        waddr     = {addr[9:2], 2'b00};
        line_hit  = m_valid[idx] && (m_tag[idx] == t);
        exp_stall = 0;
        chk_rd    = 1'b0;
        exp_rdata = '0;
        if (!mem_model.exists(waddr)) mem_model[waddr] = $urandom;
        if (wr) begin
            exp_stall = delay + 1;
            if (line_hit) m_data[idx] = wd;
        end else if (rd) begin
            chk_rd = 1'b1;
            if (line_hit) begin
                exp_rdata = m_data[idx];
            end else begin
                exp_stall    = delay + 1;
                exp_rdata    = mem_model[waddr];
                m_valid[idx] = 1'b1;
                m_tag[idx]   = t;
                m_data[idx]  = exp_rdata;
            end
        end
    endtask

    initial begin
        int          st;
        logic [31:0] rdv;
        bit          got;
        int          exp_st;
        bit          chk;
        logic [31:0] exp_rd;

        vecs[0] = '{1'b1, 1'b0, 10'h004, 32'h0,        3, 4, 1'b1, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 10'h004, 32'h0,        3, 0, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 10'h004, 32'h12345678, 2, 3, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 10'h004, 32'h0,        2, 0, 1'b1, 32'h12345678};
        vecs[4] = '{1'b0, 1'b1, 10'h084, 32'hCAFEF00D, 1, 2, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 10'h004, 32'h0,        1, 0, 1'b1, 32'h12345678};
        vecs[6] = '{1'b1, 1'b0, 10'h084, 32'h0,        2, 3, 1'b1, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 10'h004, 32'h0,        1, 2, 1'b1, 32'h12345678};
        vecs[8] = '{1'b1, 1'b1, 10'h010, 32'hA5A5A5A5, 2, 3, 1'b0, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 10'h010, 32'h0,        1, 2, 1'b1, 32'hA5A5A5A5};

        mem_model[10'h004] = 32'hDEADBEEF;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].delay, st, rdv);
            check($sformatf("vec%0d_stalls", i), 32'(st), 32'(vecs[i].exp_stall));
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdv, vecs[i].exp_rdata);
        end

        // Stray ack while idle must not disturb state or lines.
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_rd", 32'(mem_rd | mem_wr), 32'd0);
        @(posedge clk);
        #1;
        run_op(1'b1, 1'b0, 10'h010, 32'h0, 1, st, rdv);
        check("stray_ack_hit_stalls", 32'(st), 32'd0);
        check("stray_ack_hit_data", rdv, 32'hA5A5A5A5);

        // Reset in the middle of a read miss.
        MemRead = 1'b1; DataAdr = 10'h008;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (mem_rd) got = 1'b1;
        end
        check("midrst_req_seen", 32'(got), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_mem_rd", 32'(mem_rd), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_stall_idle_miss", 32'(stall), 32'd1);
        @(posedge clk);
        #1 MemRead = 1'b0; reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_mem_rd", 32'(mem_rd | mem_wr), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        run_op(1'b1, 1'b0, 10'h004, 32'h0, 2, st, rdv);
        check("post_rst_miss_stalls", 32'(st), 32'd3);
        check("post_rst_miss_data", rdv, 32'h12345678);

        // Random phase from a fresh reset.
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        for (int n = 0; n < 150; n++) begin
            bit          rd, wr;
            logic [9:0]  a;
            logic [31:0] wd;
            int          dl;
            int          kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                mem_ack = 1'b1;
                @(posedge clk);
                #1 mem_ack = 1'b0;
                @(negedge clk);
                check("rnd_stray_ack", 32'(mem_rd | mem_wr | stall), 32'd0);
                @(posedge clk);
                #1;
            end else begin
                wr = (kind <= 3);
                rd = (kind >= 3);
                a  = {3'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                wd = $urandom;
                dl = int'($urandom_range(1, 4));
                model_step(rd, wr, a, wd, dl, exp_st, chk, exp_rd);
                run_op(rd, wr, a, wd, dl, st, rdv);
                check($sformatf("rnd%0d_stalls", n), 32'(st), 32'(exp_st));
                if (chk) check($sformatf("rnd%0d_rdata", n), rdv, exp_rd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
